// File: rtl/thor2024_instr_window.sv
// Purpose : circular instruction buffer that aligns fetch beats into the decoder's five-slot window.
// Latency : a pushed beat is visible in the window one edge after it is accepted; the window read is combinational.
// Backpressure: f_ready depends only on registered occupancy and is high while a full beat still fits.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_valid/f_ready            fetch beat handshake
//   f_instr/f_cnt/f_pc         beat payload, valid count (from slot 0 upward), PC of slot 0
//   flush                      discard every buffered entry (branch redirect)
//   d_adv/d_len                consumer retires d_len (1..5) entries
//   win_instr/win_vld/win_pc   oldest five entries, per-slot valid, PC of slot 0
//   count                      occupied entries
//   err                        one-cycle pulse after an illegal advance
module thor2024_instr_window #(
  parameter int INSW    = 40,
  parameter int INSB    = 5,
  parameter int FETCH_N = 4,
  parameter int DEPTH   = 16,
  parameter int PCW     = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [FETCH_N*INSW-1:0] f_instr,
  input  logic [2:0]              f_cnt,
  input  logic [PCW-1:0]          f_pc,
  input  logic                    flush,
  input  logic                    d_adv,
  input  logic [2:0]              d_len,
  output logic [5*INSW-1:0]       win_instr,
  output logic [4:0]              win_vld,
  output logic [PCW-1:0]          win_pc,
  output logic [CW-1:0]           count,
  output logic                    err
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Storage is not reset; the window masks entries beyond count.
  logic [INSW-1:0] mem_instr [DEPTH];
  logic [PCW-1:0]  mem_pc    [DEPTH];

  logic [CW-1:0]   push_cnt;
  logic [CW-1:0]   len_ext;
  logic            push_fire;
  logic            pop_ok;
  logic            pop_fire;
  logic            pop_bad;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_n;
  logic            wr_en  [FETCH_N];
  logic [AW-1:0]   wr_idx [FETCH_N];
  logic [PCW-1:0]  wr_pc  [FETCH_N];

  // Occupancy never exceeds DEPTH, so the subtraction cannot underflow.
  assign f_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_N);

  always_comb begin
    // A count larger than the beat width is clipped to the slots that exist.
    push_cnt  = (CW'(f_cnt) > CW'(FETCH_N)) ? CW'(FETCH_N) : CW'(f_cnt);
    len_ext   = CW'(d_len);
    push_fire = f_valid & f_ready & ~flush;
    pop_ok    = (d_len != 3'd0) && (d_len <= 3'd5) && (len_ext <= count_q);
    pop_fire  = d_adv & ~flush & pop_ok;
    pop_bad   = d_adv & ~flush & ~pop_ok;
    push_n    = push_fire ? push_cnt : '0;
    pop_n     = pop_fire ? len_ext : '0;

    for (int i = 0; i < FETCH_N; i++) begin
      wr_en[i]  = push_fire && (CW'(i) < push_cnt);
      wr_idx[i] = wr_ptr_q + AW'(i);
      wr_pc[i]  = f_pc + PCW'(i * INSB);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      count_d  = count_q + push_n - pop_n;
      err_d    = pop_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Write indices of one beat are distinct because FETCH_N < DEPTH; pointer
  // arithmetic wraps naturally so a beat straddling the end lands correctly.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_N; i++) begin
      if (wr_en[i]) begin
        mem_instr[wr_idx[i]] <= f_instr[i*INSW +: INSW];
        mem_pc[wr_idx[i]]    <= wr_pc[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      win_vld[i]                 = count_q > CW'(i);
      win_instr[i*INSW +: INSW]  = win_vld[i] ? mem_instr[rd_ptr_q + AW'(i)] : '0;
    end
    win_pc = (count_q != '0) ? mem_pc[rd_ptr_q] : '0;
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: doc/thor2024_instr_window.md
Name: thor2024_instr_window

Overview:
- Instruction buffer/aligner that sources the five-instruction window (slot 0 plus up to four postfix slots) consumed by the Thor2024 decoder.
- Accepts fetch beats of FETCH_N instructions from the I-cache/fetch stage and stores them in a circular buffer.
- Presents the oldest five entries with per-slot valid bits and PCs.
- Retires a variable number of entries per cycle, equal to the decoded instruction length (1 + postfix count).

Parameters:
- INSW, 40, instruction width in bits.
- INSB, 5, instruction size in bytes (PC increment per slot).
- FETCH_N, 4, instructions per fetch beat.
- DEPTH, 16, buffer entries; power of two, ≥ FETCH_N+5.
- PCW, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fetch beat valid.
- f_ready  out  1  buffer can accept a full beat.
- f_instr  in  FETCH_N*INSW  beat instructions; slot i at bits [i*INSW +: INSW].
- f_cnt  in  3  number of valid instructions in the beat (1..FETCH_N), taken from slot 0 upward.
- f_pc  in  PCW  PC of beat slot 0.
- flush  in  1  discard all buffered entries (branch redirect).
- d_adv  in  1  consumer retires d_len entries this cycle.
- d_len  in  3  entries to retire (1..5).
- win_instr  out  5*INSW  window slots 0..4, oldest in slot 0.
- win_vld  out  5  win_vld[i] = count > i.
- win_pc  out  PCW  PC of slot 0.
- count  out  log2(DEPTH)+1  occupied entries.
- err  out  1  one-cycle pulse on an illegal advance.

Behaviour:
- Reset (async, rst_n low): rd_ptr=0, wr_ptr=0, count=0, win_vld=0, win_pc=0, err=0, f_ready=1. Storage contents are don't-care. Window data reads as 0 while win_vld=0.
- Storage: DEPTH entries of {instr, pc}. Pointers wrap modulo DEPTH.
- Push:
  - Occurs when f_valid & f_ready & !flush.
  - Writes f_cnt entries at wr_ptr..wr_ptr+f_cnt-1 (mod DEPTH); entry i gets pc = f_pc + i*INSB.
  - wr_ptr advances by f_cnt.
- f_ready = (DEPTH - count) ≥ FETCH_N. It depends on registered state only and never on same-cycle d_adv.
- Pop:
  - Legal when d_adv & 1 ≤ d_len ≤ 5 & d_len ≤ count & !flush. rd_ptr advances by d_len.
  - Illegal when d_adv & (d_len==0 | d_len>5 | d_len>count) & !flush. No pop occurs, and err pulses high for one cycle on the next edge.
- Simultaneous push and pop: both take effect; count_next = count + f_cnt - d_len.
- Flush has priority over everything:
  - rd_ptr=wr_ptr=0, count=0 on the next edge.
  - A push or pop in the same cycle is dropped; err is not raised.
  - f_ready stays as computed from the pre-flush count that cycle.
- Window:
  - Combinational read of entries rd_ptr+0..4 (mod DEPTH) from registered state.
  - Push-to-window latency is one edge.
  - Slots with win_vld[i]=0 output 0.
  - win_pc is entry[rd_ptr].pc when count>0, else 0.
- Wrap-around: entries straddling index DEPTH-1→0 appear contiguous in the window; a fetch beat that straddles the wrap is written correctly.
- Full: count never exceeds DEPTH. With DEPTH=16 and FETCH_N=4, f_ready drops at count ≥ 13.
- Empty: win_vld=0. Any d_adv is illegal and raises err.
- Reset mid-operation: all state is cleared immediately and asynchronously; the first push after rst_n deasserts behaves as after a fresh reset.

Test Plan:
- Reset, then push f_cnt=4 at f_pc=0x1000 → next cycle count=4, win_vld=5'b01111, win_pc=0x1000, slot 3 pc-equivalent 0x100F.
- Push two beats (4+4), then d_adv d_len=3 → count=5, win_pc=0x100F, win_vld=5'b11111, slot 0 = original 4th instruction.
- Keep f_valid high with no pops → count saturates at 16 (beats at 0,4,8,12); f_ready=0 at count 13..16; a fifth beat is not accepted.
- Run 10 cycles of push 4 / pop 4 to force pointer wrap → window data and PCs stay continuous across index 15→0; count is constant.
- Same cycle: flush=1, f_valid=1, d_adv=1 with count=8 → next cycle count=0, win_vld=0, err=0.
- count=2, d_adv with d_len=3; then d_len=0; then d_len=6 → each raises a one-cycle err pulse, count stays 2, and the window is unchanged.
